alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples before a button level is accepted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; assertion SHALL take effect immediately, deassertion SHALL be sampled on clk.
REQ-004 sw  input  4  raw data switches; operand value, or opcode on sw[2:0].
REQ-005 btn_next  input  1  raw, asynchronous, active-high "enter" button.
REQ-006 btn_clr  input  1  raw, asynchronous, active-high "clear" button.
REQ-007 op_a  output  4  latched operand A to the ALU.
REQ-008 op_b  output  4  latched operand B to the ALU.
REQ-009 op_sel  output  3  latched ALU opcode (000 add … 111 equal).
REQ-010 cmd_valid  output  1  command presented to the ALU.
REQ-011 cmd_ready  input  1  ALU accepts the command (tied high for the combinational ALU).
REQ-012 alu_result  input  4  ALU result, two's complement; sampled only on acceptance.
REQ-013 result  output  4  captured result.
REQ-014 result_valid  output  1  result holds a completed command.
REQ-015 stage  output  3  one-hot entry indicator: 001 GET_A, 010 GET_B, 100 GET_OP, 000 otherwise.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free sample resets the count.
REQ-017 A press pulse SHALL be exactly one cycle, on the debounced 0->1 transition; releases, glitches shorter than DEBOUNCE_CYCLES and a held button SHALL produce no further pulse.
REQ-018 With a clean step held, the pulse SHALL assert 2+DEBOUNCE_CYCLES cycles after the first edge sampling the raw input high.
REQ-019 States: GET_A, GET_B, GET_OP, ISSUE, HOLD.
REQ-020 GET_A + next pulse: op_a <= sw; -> GET_B.
REQ-021 GET_B + next pulse: op_b <= sw; -> GET_OP.
REQ-022 GET_OP + next pulse: op_sel <= sw[2:0]; -> ISSUE (sw[3] ignored).
REQ-023 ISSUE: cmd_valid = 1; op_a/op_b/op_sel SHALL remain stable until acceptance.
REQ-024 Acceptance = cmd_valid & cmd_ready on a rising edge: result <= alu_result, result_valid <= 1, -> HOLD; cmd_valid SHALL be 0 the next cycle.
REQ-025 ISSUE with cmd_ready low SHALL wait indefinitely; next pulses in ISSUE SHALL be ignored.
REQ-026 HOLD + next pulse: result_valid <= 0; -> GET_A; op_a, op_b, op_sel, result retain values until overwritten.
REQ-027 Clear pulse in any state SHALL -> GET_A and zero op_a, op_b, op_sel, result, result_valid; cmd_valid SHALL be 0 the next cycle with no acceptance.
REQ-028 Clear and next pulses in the same cycle: clear SHALL win; next discarded.
REQ-029 Clear in ISSUE in the same cycle as cmd_ready: clear SHALL win; result not captured.
REQ-030 cmd_valid SHALL be a registered function of state; no combinational path from cmd_ready to cmd_valid.
REQ-031 Nothing SHALL be interpreted arithmetically; result is stored bit-exact.

Reset
REQ-032 On rst_n low: state GET_A; op_a = 0, op_b = 0, op_sel = 0, result = 0, result_valid = 0, cmd_valid = 0, stage = 001; synchronizers, debounce counters and debounced levels = 0.
REQ-033 Reset mid-operation (any state, including ISSUE) SHALL discard the command without acceptance.
REQ-034 A button held through reset release SHALL produce one pulse only after debouncing completes.

Verification (DEBOUNCE_CYCLES = 4, cmd_ready = 1, alu_result driven by a model of the ALU)
REQ-035 sw=0011 press, sw=0101 press, sw=x000 press -> op_a=3, op_b=5, op_sel=000, cmd_valid 1 cycle, result=1000, result_valid=1, stage=000.
REQ-036 btn_next raw pulse of 3 cycles, then bouncing 1-cycle toggles -> no pulse, stage stays 001; 10-cycle hold -> exactly one pulse, 6 cycles after the rise.
REQ-037 cmd_ready=0 in ISSUE for 20 cycles -> cmd_valid and operands stable; raise cmd_ready, alu_result=1110 -> result=1110 captured same edge, cmd_valid 0 next cycle.
REQ-038 Clear and next debounced in the same cycle while in GET_B -> state GET_A, op_a=0, stage=001.
REQ-039 rst_n low asynchronously mid-ISSUE, with clk stopped -> cmd_valid=0, result_valid=0 immediately.
REQ-040 HOLD + next press -> result_valid=0, stage=001, result unchanged until next acceptance.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Purpose : command/result bundle between the operand sequencer and the ALU.
// Ports   : op_a/op_b/op_sel/cmd_valid flow sequencer->ALU; cmd_ready/alu_result flow back.
// Handshake: a command is accepted on a rising edge where cmd_valid & cmd_ready.
interface alu_cmd_sequencer_if;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [2:0] op_sel;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] alu_result;

  modport master (
    output op_a, op_b, op_sel, cmd_valid,
    input  cmd_ready, alu_result
  );

  modport slave (
    input  op_a, op_b, op_sel, cmd_valid,
    output cmd_ready, alu_result
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Purpose : collects operand A, operand B and opcode from switches on debounced
//           "next" presses, issues the command to the ALU and holds the result.
// Latency : press pulse 2+DEBOUNCE_CYCLES cycles after raw rise; state moves one cycle later.
// Backpressure: ISSUE waits indefinitely for cmd_ready; operands stay frozen meanwhile.
// Ports   : clk, rst_n (async active-low), sw[3:0], btn_next, btn_clr (raw buttons),
//           alu (master modport: op_a/op_b/op_sel/cmd_valid out, cmd_ready/alu_result in),
//           result[3:0], result_valid, stage[2:0] (one-hot GET_A/GET_B/GET_OP indicator).
module alu_cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  sw,
  input  logic                        btn_next,
  input  logic                        btn_clr,
  alu_cmd_sequencer_if.master         alu,
  output logic [3:0]                  result,
  output logic                        result_valid,
  output logic [2:0]                  stage
);

  localparam logic [2:0] ST_GET_A  = 3'd0;
  localparam logic [2:0] ST_GET_B  = 3'd1;
  localparam logic [2:0] ST_GET_OP = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Button channels: bit 0 = next, bit 1 = clear.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [1:0] deb_d;
  logic [1:0] pulse;
  logic [7:0] cnt [2];

  logic next_pulse;
  logic clr_pulse;

  logic [2:0] state;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [2:0] op_sel;

  assign raw = {btn_clr, btn_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_d  <= '0;
      pulse  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      // Registered edge detect keeps the pulse exactly one cycle wide and
      // lands it 2+DEBOUNCE_CYCLES edges after the raw input is first seen.
      pulse <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i] <= '0;
          deb[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  assign next_pulse = pulse[0];
  assign clr_pulse  = pulse[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_GET_A;
      op_a         <= '0;
      op_b         <= '0;
      op_sel       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (clr_pulse) begin
      // Clear outranks both a simultaneous next press and a same-cycle acceptance.
      state        <= ST_GET_A;
      op_a         <= '0;
      op_b         <= '0;
      op_sel       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_GET_A: if (next_pulse) begin
          op_a  <= sw;
          state <= ST_GET_B;
        end
        ST_GET_B: if (next_pulse) begin
          op_b  <= sw;
          state <= ST_GET_OP;
        end
        ST_GET_OP: if (next_pulse) begin
          op_sel <= sw[2:0];
          state  <= ST_ISSUE;
        end
        ST_ISSUE: if (alu.cmd_ready) begin
          result       <= alu.alu_result;
          result_valid <= 1'b1;
          state        <= ST_HOLD;
        end
        ST_HOLD: if (next_pulse) begin
          result_valid <= 1'b0;
          state        <= ST_GET_A;
        end
        default: state <= ST_GET_A;
      endcase
    end
  end

  // Decoded straight from the state register, so cmd_ready never reaches cmd_valid.
  assign alu.cmd_valid = (state == ST_ISSUE);
  assign alu.op_a      = op_a;
  assign alu.op_b      = op_b;
  assign alu.op_sel    = op_sel;

  always_comb begin
    stage = 3'b000;
    case (state)
      ST_GET_A:  stage = 3'b001;
      ST_GET_B:  stage = 3'b010;
      ST_GET_OP: stage = 3'b100;
      default:   stage = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Purpose : self-checking bench for alu_cmd_sequencer with DEBOUNCE_CYCLES = 4.
// Latency : presses take 8 high + 8 low cycles; pulse expected 6 edges after raw rise.
// Backpressure: cmd_ready is held low in selected scenarios to stall ISSUE.
module tb_alu_cmd_sequencer;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n = 1'b1;
  logic [3:0] sw = 4'h0;
  logic       btn_next = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] result;
  logic       result_valid;
  logic [2:0] stage;
  logic       alu_ovr = 1'b0;
  logic [3:0] ovr_val = 4'h0;

  int checks = 0;
  int failures = 0;
  int npulses = 0;

  alu_cmd_sequencer_if ifc();

  alu_cmd_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .btn_next     (btn_next),
    .btn_clr      (btn_clr),
    .alu          (ifc),
    .result       (result),
    .result_valid (result_valid),
    .stage        (stage)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  // Reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not-a, 110 a<b, 111 a==b.
  function automatic logic [3:0] alu_model(logic [3:0] a, logic [3:0] b, logic [2:0] s);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return {3'b000, (a < b)};
      default: return {3'b000, (a == b)};
    endcase
  endfunction

  always_comb ifc.alu_result = alu_ovr ? ovr_val : alu_model(ifc.op_a, ifc.op_b, ifc.op_sel);

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] res;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op_sw;
    logic [2:0] exp_sel;
    logic [3:0] exp_res;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  logic pend = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_next(logic [3:0] v);
    sw = v;
    btn_next = 1'b1;
    step(8);
    btn_next = 1'b0;
    step(8);
  endtask

  // Acceptance monitor: an upcoming handshake edge is seen at the preceding negedge.
  always @(negedge clk) begin
    if (dut.next_pulse) npulses++;
    if (pend) begin
      pend = 1'b0;
      chk("acc_result", int'(result), int'(cur.res));
      chk("acc_result_valid", int'(result_valid), 1);
      chk("acc_cmd_valid_drop", int'(ifc.cmd_valid), 0);
    end
    if (rst_n && ifc.cmd_valid && ifc.cmd_ready && !dut.clr_pulse) begin
      if (sb.size() == 0) begin
        chk("acc_unexpected", 1, 0);
      end else begin
        cur = sb.pop_front();
        chk("acc_op_a", int'(ifc.op_a), int'(cur.a));
        chk("acc_op_b", int'(ifc.op_b), int'(cur.b));
        chk("acc_op_sel", int'(ifc.op_sel), int'(cur.sel));
        pend = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int   bad;
    int   first;
    int   cnt;
    int   p0;
    logic found;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  op_sw: 4'b1000, exp_sel: 3'd0, exp_res: 4'b1000};
    vecs[1] = '{a: 4'd9,  b: 4'd4,  op_sw: 4'h1,    exp_sel: 3'd1, exp_res: 4'd5};
    vecs[2] = '{a: 4'd12, b: 4'd10, op_sw: 4'h2,    exp_sel: 3'd2, exp_res: 4'd8};
    vecs[3] = '{a: 4'd12, b: 4'd10, op_sw: 4'h3,    exp_sel: 3'd3, exp_res: 4'd14};
    vecs[4] = '{a: 4'd12, b: 4'd10, op_sw: 4'h4,    exp_sel: 3'd4, exp_res: 4'd6};
    vecs[5] = '{a: 4'd5,  b: 4'd0,  op_sw: 4'hD,    exp_sel: 3'd5, exp_res: 4'd10};
    vecs[6] = '{a: 4'd2,  b: 4'd9,  op_sw: 4'h6,    exp_sel: 3'd6, exp_res: 4'd1};
    vecs[7] = '{a: 4'd7,  b: 4'd7,  op_sw: 4'h7,    exp_sel: 3'd7, exp_res: 4'd1};
    vecs[8] = '{a: 4'd15, b: 4'd1,  op_sw: 4'h0,    exp_sel: 3'd0, exp_res: 4'd0};

    ifc.cmd_ready = 1'b1;
    #2 rst_n = 1'b0;
    step(3);
    chk("rst_op_a", int'(ifc.op_a), 0);
    chk("rst_op_b", int'(ifc.op_b), 0);
    chk("rst_op_sel", int'(ifc.op_sel), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_cmd_valid", int'(ifc.cmd_valid), 0);
    chk("rst_stage", int'(stage), 1);
    rst_n = 1'b1;
    step(2);

    // Table-driven full command cycles.
    for (int i = 0; i < 9; i++) begin
      press_next(vecs[i].a);
      chk("vec_stage_b", int'(stage), 2);
      press_next(vecs[i].b);
      chk("vec_stage_op", int'(stage), 4);
      sb.push_back('{a: vecs[i].a, b: vecs[i].b, sel: vecs[i].exp_sel, res: vecs[i].exp_res});
      press_next(vecs[i].op_sw);
      chk("vec_result", int'(result), int'(vecs[i].exp_res));
      chk("vec_result_valid", int'(result_valid), 1);
      chk("vec_stage_hold", int'(stage), 0);
      chk("vec_sb_empty", sb.size(), 0);
      press_next(4'h0);
      chk("hold_result_valid", int'(result_valid), 0);
      chk("hold_stage", int'(stage), 1);
      chk("hold_result_kept", int'(result), int'(vecs[i].exp_res));
    end

    // Short pulse and bouncing must not produce a press.
    p0 = npulses;
    sw = 4'h6;
    btn_next = 1'b1; step(3);
    btn_next = 1'b0; step(3);
    for (int k = 0; k < 10; k++) begin
      btn_next = ~btn_next;
      step(1);
    end
    btn_next = 1'b0;
    step(8);
    chk("bounce_pulses", npulses - p0, 0);
    chk("bounce_stage", int'(stage), 1);

    // Clean 10-cycle hold: one pulse, 6 edges after the first high sample.
    first = -1;
    cnt = 0;
    btn_next = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (dut.next_pulse) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k == 9) btn_next = 1'b0;
    end
    chk("hold10_pulse_count", cnt, 1);
    chk("hold10_pulse_edge", first, 2 + DB);
    chk("hold10_stage", int'(stage), 2);
    chk("hold10_op_a", int'(ifc.op_a), 6);

    // Stall ISSUE for 20 cycles, then accept a forced result.
    ifc.cmd_ready = 1'b0;
    press_next(4'h2);
    sb.push_back('{a: 4'd6, b: 4'd2, sel: 3'd1, res: 4'b1110});
    press_next(4'h1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (ifc.cmd_valid !== 1'b1 || ifc.op_a !== 4'd6 || ifc.op_b !== 4'd2 ||
          ifc.op_sel !== 3'd1 || result_valid !== 1'b0) bad++;
    end
    chk("stall_stable", bad, 0);
    alu_ovr = 1'b1;
    ovr_val = 4'b1110;
    ifc.cmd_ready = 1'b1;
    step(3);
    alu_ovr = 1'b0;
    chk("stall_result", int'(result), 14);
    chk("stall_sb_empty", sb.size(), 0);
    press_next(4'h0);
    chk("stall_hold_exit", int'(stage), 1);
    chk("stall_result_kept", int'(result), 14);

    // Clear and next together while in GET_B: clear wins.
    press_next(4'h6);
    chk("clrnext_pre_stage", int'(stage), 2);
    sw = 4'h9;
    btn_next = 1'b1;
    btn_clr = 1'b1;
    step(8);
    btn_next = 1'b0;
    btn_clr = 1'b0;
    step(8);
    chk("clrnext_stage", int'(stage), 1);
    chk("clrnext_op_a", int'(ifc.op_a), 0);
    chk("clrnext_result", int'(result), 0);

    // Clear on the same edge as cmd_ready in ISSUE: nothing captured.
    ifc.cmd_ready = 1'b0;
    alu_ovr = 1'b1;
    ovr_val = 4'hB;
    press_next(4'h1);
    press_next(4'h2);
    press_next(4'h0);
    chk("clrrdy_in_issue", int'(ifc.cmd_valid), 1);
    btn_clr = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (dut.clr_pulse) begin
        ifc.cmd_ready = 1'b1;
        found = 1'b1;
      end
    end
    chk("clrrdy_pulse_seen", int'(found), 1);
    step(2);
    btn_clr = 1'b0;
    step(8);
    alu_ovr = 1'b0;
    chk("clrrdy_result", int'(result), 0);
    chk("clrrdy_result_valid", int'(result_valid), 0);
    chk("clrrdy_stage", int'(stage), 1);
    chk("clrrdy_op_a", int'(ifc.op_a), 0);

    // Asynchronous reset mid-ISSUE with the clock stopped.
    ifc.cmd_ready = 1'b0;
    press_next(4'h3);
    press_next(4'h3);
    press_next(4'h0);
    chk("arst_pre_cmd_valid", int'(ifc.cmd_valid), 1);
    @(negedge clk);
    clk_en = 1'b0;
    #20;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_valid", int'(ifc.cmd_valid), 0);
    chk("arst_result_valid", int'(result_valid), 0);
    chk("arst_stage", int'(stage), 1);
    chk("arst_op_a", int'(ifc.op_a), 0);

    // Button held through reset release: one press after full debounce.
    ifc.cmd_ready = 1'b1;
    sw = 4'hA;
    btn_next = 1'b1;
    clk_en = 1'b1;
    step(3);
    rst_n = 1'b1;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (first < 0 && stage != 3'b001) first = k;
    end
    chk("rst_held_latency", first, 3 + DB);
    chk("rst_held_op_a", int'(ifc.op_a), 10);
    btn_next = 1'b0;
    step(8);
    chk("rst_held_stage", int'(stage), 2);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
